// File: rtl/axi_pkg.sv
// Shared definitions for the AXI write path: response codes, FSM states,
// request entry width and a saturating counter helper.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Queue entry layout: {addr[31:0], data[31:0], strb[3:0]}
  localparam int REQ_W = 68;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axi_req_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra bit so that
// full and empty are distinguishable without a separate count.
module axi_req_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/axi4_write_master.sv
// Single-outstanding AXI4-Lite write initiator fed from a request queue.
// Optional response watchdog enabled by defining AXI_WR_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a queued request
// ADDR  | AW and W offered, each retired on its own handshake
// RESP  | bready high, waiting for the B response
module axi4_write_master
  import axi_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_strb,
  output logic        done_valid,
  output logic [1:0]  done_resp,
  output logic        busy,
  output logic [7:0]  err_count,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t           state;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [REQ_W-1:0] fifo_head;
  logic             aw_pending;
  logic             w_pending;

  assign req_ready  = reset && !fifo_full;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign aw_pending = awvalid && !awready;
  assign w_pending  = wvalid && !wready;

  axi_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid && req_ready),
    .push_data ({req_addr, req_data, req_strb}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef AXI_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      awaddr     <= '0;
      wdata      <= '0;
      wstrb      <= 4'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      done_valid <= 1'b0;
      done_resp  <= RESP_OKAY;
      err_count  <= '0;
`ifdef AXI_WR_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {awaddr, wdata, wstrb} <= fifo_head;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= ADDR;
`ifdef AXI_WR_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        ADDR: begin
          awvalid <= aw_pending;
          wvalid  <= w_pending;
          if (!aw_pending && !w_pending) begin
            bready <= 1'b1;
            state  <= RESP;
          end
        end
        RESP: begin
          if (bvalid) begin
            done_resp  <= bresp;
            done_valid <= 1'b1;
            bready     <= 1'b0;
            state      <= IDLE;
            if (bresp != RESP_OKAY) err_count <= sat_inc8(err_count);
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXI_WR_TIMEOUT_EN
      // A real B handshake on the terminal cycle wins over the watchdog.
      if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_hit && !(state == RESP && bvalid)) begin
          awvalid    <= 1'b0;
          wvalid     <= 1'b0;
          bready     <= 1'b0;
          done_valid <= 1'b1;
          done_resp  <= RESP_SLVERR;
          err_count  <= sat_inc8(err_count);
          state      <= IDLE;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4_write_master.sv
// Bench for axi4_write_master: directed vectors and sequences plus random
// traffic checked against a queue-based transaction model.
module tb_axi4_write_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_strb;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic        busy;
  logic [7:0]  err_count;
  logic [31:0] awaddr, wdata;
  logic        awvalid, awready, wvalid, wready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  axi4_write_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .done_valid(done_valid), .done_resp(done_resp), .busy(busy), .err_count(err_count),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, got, exp);
    end
  endtask

  // Transaction model: accepted requests in order, responses handed over on B
  logic [67:0] exp_q[$];
  logic [1:0]  resp_q[$];
  int          model_err = 0;
  int          completions = 0;
  int          total_pushes = 0;
  bit          aw_seen = 0, w_seen = 0;
  bit          prev_aw_pend = 0, prev_w_pend = 0;
  logic [31:0] prev_awaddr, prev_wdata;
  logic [3:0]  prev_wstrb;

  task automatic step();
    bit push_now, aw_hs, w_hs, b_hs, in_rst;
    logic [67:0] ent;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [1:0]  r;
    #1;
    in_rst   = !reset;
    push_now = req_valid && req_ready;
    ent      = {req_addr, req_data, req_strb};
    aw_hs    = awvalid && awready;
    w_hs     = wvalid && wready;
    b_hs     = bvalid && bready;
    a = awaddr; d = wdata; s = wstrb; r = bresp;
    if (!in_rst && prev_aw_pend && awvalid) chk("aw_stable", a, prev_awaddr);
    if (!in_rst && prev_w_pend && wvalid) chk("w_stable", {d, s}, {prev_wdata, prev_wstrb});
    prev_aw_pend = awvalid && !awready;
    prev_w_pend  = wvalid && !wready;
    prev_awaddr = a; prev_wdata = d; prev_wstrb = s;
    @(negedge clk);
    if (in_rst) begin
      exp_q.delete(); resp_q.delete();
      model_err = 0; aw_seen = 0; w_seen = 0;
      prev_aw_pend = 0; prev_w_pend = 0;
      return;
    end
    if (push_now) begin
      exp_q.push_back(ent);
      total_pushes++;
    end
    if (aw_hs) begin
      chk("aw_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("awaddr", a, exp_q[0][67:36]);
      aw_seen = 1;
    end
    if (w_hs) begin
      chk("w_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("wdata_wstrb", {d, s}, exp_q[0][35:0]);
      w_seen = 1;
    end
    if (aw_seen && w_seen) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      aw_seen = 0; w_seen = 0;
    end
    if (b_hs) begin
      resp_q.push_back(r);
      if (r != 2'b00 && model_err < 255) model_err++;
    end
    if (done_valid) begin
      chk("done_expected", resp_q.size() != 0, 1);
      if (resp_q.size() != 0) chk("done_resp", done_resp, resp_q.pop_front());
      chk("err_count", err_count, model_err);
      completions++;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[6];
  int   base, push_base, n;
  bit   exp_aw, exp_w;

  initial begin
    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 8'd0};
    vecs[1] = '{32'h0000_0020, 32'h1234_5678, 4'h3, 2'b10, 8'd1};
    vecs[2] = '{32'h0000_0024, 32'hCAFE_F00D, 4'h8, 2'b00, 8'd1};
    vecs[3] = '{32'h0000_0028, 32'h0BAD_C0DE, 4'hC, 2'b10, 8'd2};
    vecs[4] = '{32'h0000_002C, 32'h5555_AAAA, 4'h1, 2'b11, 8'd3};
    vecs[5] = '{32'h0000_0030, 32'hFFFF_0001, 4'h5, 2'b01, 8'd4};

    reset = 1'b0; req_valid = 0; req_addr = 0; req_data = 0; req_strb = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;

    // Reset values
    repeat (2) step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ctrl", {awvalid, wvalid, bready, done_valid, busy}, 5'b0);
    chk("rst_regs", {err_count, awaddr, wdata, wstrb, done_resp}, 78'b0);
    reset = 1'b1;
    step();
    chk("release_req_ready", req_ready, 1);

    // Single writes with an always-ready slave
    for (int i = 0; i < 6; i++) begin
      req_addr = vecs[i].addr; req_data = vecs[i].data; req_strb = vecs[i].strb;
      req_valid = 1; awready = 1; wready = 1; bvalid = 1; bresp = vecs[i].bresp;
      step();
      req_valid = 0;
      chk("t_not_yet_issued", awvalid, 0);
      step();
      chk("t_issue", {awvalid, wvalid, awaddr, wdata, wstrb},
          {2'b11, vecs[i].addr, vecs[i].data, vecs[i].strb});
      step();
      chk("t_aw_one_cycle", {awvalid, wvalid, bready}, 3'b001);
      step();
      chk("t_done", {done_valid, done_resp, err_count}, {1'b1, vecs[i].bresp, vecs[i].exp_err});
      step();
      chk("t_done_pulse", {done_valid, bready, busy}, 3'b000);
    end

    // Independent AW/W stalls: awready late by 3, wready late by 5
    awready = 0; wready = 0; bvalid = 0;
    req_addr = 32'h100; req_data = 32'hA5A5_5A5A; req_strb = 4'h6; req_valid = 1;
    step();
    req_valid = 0;
    step();
    chk("s_issue", {awvalid, wvalid}, 2'b11);
    exp_aw = 1; exp_w = 1;
    for (int i = 0; i < 7; i++) begin
      awready = (i >= 3);
      wready  = (i >= 5);
      step();
      if (awready) exp_aw = 0;
      if (wready)  exp_w  = 0;
      chk("s_valids", {awvalid, wvalid, bready}, {exp_aw, exp_w, !exp_aw && !exp_w});
      chk("s_payload", {awaddr, wdata, wstrb}, {32'h100, 32'hA5A5_5A5A, 4'h6});
    end
    bvalid = 1; bresp = 2'b00;
    step();
    chk("s_done", {done_valid, done_resp}, 3'b100);
    bvalid = 0;
    step();

    // Fill the queue behind a stalled slave, then drain in order
    awready = 0; wready = 0; bvalid = 0;
    for (int k = 0; k < 5; k++) begin
      req_addr = 32'h200 + 32'(k * 4); req_data = 32'h1000_0000 + 32'(k); req_strb = 4'hF;
      req_valid = 1;
      #1 chk("f_ready_before_push", req_ready, 1);
      step();
    end
    req_valid = 0;
    #1;
    chk("f_full", req_ready, 0);
    chk("f_busy", busy, 1);
    base = completions;
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
    for (int c = 0; c < 80 && completions < base + 5; c++) step();
    chk("f_all_done", completions - base, 5);
    step();
    chk("f_idle", busy, 0);

    // Random traffic against the model
    base = completions; push_base = total_pushes;
    for (int c = 0; c < 3000 && completions - base < 40; c++) begin
      req_valid = (total_pushes - push_base < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_addr  = $urandom; req_data = $urandom; req_strb = 4'($urandom_range(0, 15));
      awready   = 1'($urandom_range(0, 1));
      wready    = 1'($urandom_range(0, 1));
      bvalid    = 1'($urandom_range(0, 1));
      bresp     = 2'($urandom_range(0, 3));
      step();
    end
    req_valid = 0;
    chk("r_completions", completions - base, 40);

    // Reset while waiting in RESP with two requests queued behind it
    awready = 1; wready = 1; bvalid = 0; req_valid = 1;
    req_addr = 32'h300; step();
    req_addr = 32'h304; step();
    req_addr = 32'h308; step();
    req_valid = 0;
    for (int c = 0; c < 10 && !bready; c++) step();
    chk("m_in_resp", bready, 1);
    reset = 0; bvalid = 1;
    step();
    chk("m_rst_ctrl", {awvalid, wvalid, bready, done_valid, busy, req_ready}, 6'b0);
    chk("m_rst_regs", {err_count, awaddr, wdata, wstrb, done_resp}, 78'b0);
    reset = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("m_after_rst", {done_valid, awvalid, busy}, 3'b000);
    end
    bvalid = 0;

    // Error counter saturation
    awready = 1; wready = 1; bvalid = 1; req_valid = 1; base = completions;
    for (int c = 0; c < 3000 && completions - base < 300; c++) begin
      req_addr = $urandom; req_data = $urandom;
      bresp = (c % 2 != 0) ? 2'b10 : 2'b11;
      step();
    end
    req_valid = 0;
    chk("sat_count", completions - base, 300);
    chk("sat_err", err_count, 8'd255);
    for (int c = 0; c < 40 && busy; c++) step();
    chk("sat_drained", busy, 0);

`ifdef AXI_WR_TIMEOUT_EN
    // Watchdog: bvalid never arrives
    reset = 0; step(); reset = 1; step();
    awready = 1; wready = 1; bvalid = 0;
    req_addr = 32'h400; req_data = 32'h0; req_strb = 4'hF; req_valid = 1;
    step();
    req_valid = 0;
    step();
    chk("to_issue", awvalid, 1);
    resp_q.push_back(2'b10);
    model_err++;
    n = 0;
    for (int c = 0; c < 40 && !done_valid; c++) begin
      step();
      n++;
    end
    chk("to_latency", n, 16);
    chk("to_resp", {done_valid, done_resp, err_count}, {1'b1, 2'b10, 8'd1});
    step();
    chk("to_idle", {busy, bready, awvalid, wvalid}, 4'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_write_master.md
Name: axi4_write_master

Overview:
Upstream AXI4-Lite-style write initiator that feeds the AXI4 write slave. It accepts single-beat write requests (address, data, strobes) from the core or NoC-side logic into a small request FIFO. It drives the AW and W channels with independent handshakes, then collects the B response. Each result is reported on a one-cycle completion strobe, and a saturating error counter is kept.

Parameters:
FIFO_DEPTH, 4, request queue entries (power of two, at least 2)
TIMEOUT_CYCLES, 256, response watchdog limit (used only with AXI_WR_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = in reset)
req_valid  in  1  request offered
req_ready  out  1  queue can accept (= not full)
req_addr  in  32  write address
req_data  in  32  write data
req_strb  in  4  byte strobes
done_valid  out  1  one-cycle pulse when a transaction completes
done_resp  out  2  response for the completed transaction
busy  out  1  FSM not IDLE or queue not empty
err_count  out  8  saturating count of non-OKAY responses
awaddr  out  32  write address
awvalid  out  1  address valid
awready  in  1  slave address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  data valid
wready  in  1  slave data ready
bresp  in  2  slave response
bvalid  in  1  response valid
bready  out  1  master ready for response

Behaviour:
- Reset (reset=0 at a clock edge): FIFO empty and pointers 0. FSM goes to IDLE. awvalid, wvalid, bready, done_valid and busy are 0. err_count, awaddr, wdata, done_resp are 0. wstrb is 4'b0. req_ready is 0 while reset=0 and 1 in the first cycle after release.
- Queue: a push occurs on req_valid && req_ready. No push is possible when full. Push and pop in the same cycle are legal; count is unchanged. Pointers wrap modulo FIFO_DEPTH, with one extra bit to distinguish full from empty.
- IDLE: if the queue is not empty, pop the head into awaddr/wdata/wstrb and set awvalid=wvalid=1; go to ADDR. Latency: a request pushed at edge N into an empty queue makes awvalid/wvalid high after edge N+1.
- ADDR: awvalid drops on the edge where awvalid&&awready. wvalid drops on the edge where wvalid&&wready. These are tracked independently, in either order or the same cycle. Payload stays stable while its valid is high. When both are done (including both completing on the same edge), set bready=1 and go to RESP. awready/wready may be high before valid; this causes no early transfer.
- RESP: on bvalid&&bready, capture bresp into done_resp, pulse done_valid for one cycle, and clear bready. If bresp≠2'b00, increment err_count, saturating at 255. Return to IDLE.
- The next transaction can issue on the cycle after done_valid. There is at most one transaction outstanding.
- bvalid seen outside RESP is ignored.
- Reset asserted mid-transaction aborts it immediately. No done pulse is produced and queued requests are lost.

Optional Feature:
AXI_WR_TIMEOUT_EN:
- Defined: a counter clears on entry to ADDR and increments each cycle in ADDR or RESP. On reaching TIMEOUT_CYCLES, the FSM drops awvalid, wvalid and bready and pulses done_valid with done_resp=2'b10 (SLVERR). It increments err_count and returns to IDLE.
- Undefined: no counter exists, the FSM waits indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package `axi_pkg`: response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; FSM state encodings IDLE/ADDR/RESP; request entry width constant (68).
- One sub-module, `axi_req_fifo`: a synchronous FIFO parameterised on width and depth, providing full/empty, push/pop and show-ahead head data.

Test Plan:
- Single write, addr=0x10, data=0xDEADBEEF, strb=0xF, awready=wready=bvalid=1, bresp=0 → awvalid/wvalid high for exactly one cycle; done_valid pulse with done_resp=0; err_count=0.
- awready held low 3 cycles and wready low 5 cycles → awvalid drops after the AW handshake while wvalid stays high; bready rises only after both handshakes; payload stable throughout.
- Push 5 requests back-to-back with FIFO_DEPTH=4 and the slave stalled → req_ready=0 after 4 are queued; after release, all entries complete in push order with matching awaddr/wdata.
- bresp=2'b10 on 2 of 3 transactions → done_resp follows bresp per transaction; err_count=2. Force 300 errors → err_count=255.
- reset=0 for one cycle while in RESP → all outputs at reset values next cycle; no done_valid; queue empty.
- With AXI_WR_TIMEOUT_EN and TIMEOUT_CYCLES=16, bvalid never asserted → done_valid with done_resp=2'b10 16 cycles after ADDR entry; err_count=1; FSM returns to IDLE.
